// File: rtl/fib_arbiter.sv
// Round-robin arbiter sharing one Fibonacci engine among NCH requesters, one request in flight.
// Optional response watchdog enabled by defining FIB_ARB_TIMEOUT_EN.
module fib_arbiter #(
    parameter int unsigned NCH     = 4,
    parameter int unsigned CH_W    = 2,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              CLK,
    input  logic              RESET_n,
    input  logic [NCH-1:0]    REQ_VALID,
    input  logic [NCH*32-1:0] REQ_DATA,
    output logic [NCH-1:0]    REQ_READY,
    input  logic              ENG_READY,
    output logic              ENG_VALID,
    output logic [31:0]       ENG_DATA,
    input  logic              ENG_RSP_VALID,
    input  logic [31:0]       ENG_RSP_DATA,
    input  logic              ENG_RSP_ERROR,
    output logic              RSP_VALID,
    input  logic              RSP_READY,
    output logic [31:0]       RSP_DATA,
    output logic              RSP_ERROR,
    output logic [CH_W-1:0]   RSP_CHANNEL,
    output logic              BUSY
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e          state_q, state_d;
    logic [CH_W-1:0] ptr_q, ptr_d;
    logic [CH_W-1:0] tag_q, tag_d;
    logic            eng_valid_q, eng_valid_d;
    logic [31:0]     eng_data_q, eng_data_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [31:0]     rsp_data_q, rsp_data_d;
    logic            rsp_error_q, rsp_error_d;
    logic [CH_W-1:0] rsp_channel_q, rsp_channel_d;

`ifdef FIB_ARB_TIMEOUT_EN
    localparam int unsigned CntW = (TIMEOUT > 255) ? 16 : 8;
    logic [CntW-1:0] cnt_q, cnt_d;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
`endif

    logic            grant_vld;
    logic [CH_W-1:0] grant_idx;
    logic [CH_W-1:0] cand;
    logic [31:0]     grant_data;

    // First valid channel at or above the pointer, wrapping modulo NCH.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            cand = CH_W'((32'(ptr_q) + i) % NCH);
            if (!grant_vld && REQ_VALID[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    always_comb begin
        grant_data = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            if (grant_idx == CH_W'(k)) begin
                grant_data = REQ_DATA[32*k +: 32];
            end
        end
    end

    // Reset gates the grant so a held REQ_VALID cannot see a ready while reset is asserted.
    always_comb begin
        REQ_READY = '0;
        if (RESET_n && state_q == StIdle && grant_vld) begin
            REQ_READY[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        tag_d         = tag_q;
        eng_valid_d   = eng_valid_q;
        eng_data_d    = eng_data_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_data_d    = rsp_data_q;
        rsp_error_d   = rsp_error_q;
        rsp_channel_d = rsp_channel_q;
`ifdef FIB_ARB_TIMEOUT_EN
        cnt_d         = cnt_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (grant_vld) begin
                    eng_data_d  = grant_data;
                    eng_valid_d = 1'b1;
                    tag_d       = grant_idx;
                    ptr_d       = (grant_idx == CH_W'(NCH - 1)) ? '0 : grant_idx + CH_W'(1);
                    state_d     = StIssue;
                end
            end
            StIssue: begin
                if (ENG_READY) begin
                    eng_valid_d = 1'b0;
                    state_d     = StWait;
`ifdef FIB_ARB_TIMEOUT_EN
                    cnt_d       = '0;
`endif
                end
            end
            StWait: begin
                if (ENG_RSP_VALID) begin
                    rsp_data_d    = ENG_RSP_DATA;
                    rsp_error_d   = ENG_RSP_ERROR;
                    rsp_channel_d = tag_q;
                    rsp_valid_d   = 1'b1;
                    state_d       = StResp;
                end
`ifdef FIB_ARB_TIMEOUT_EN
                // Synthesised error response; any later engine response lands outside WAIT.
                else if (cnt_q == CntW'(TIMEOUT - 1)) begin
                    rsp_data_d    = '0;
                    rsp_error_d   = 1'b1;
                    rsp_channel_d = tag_q;
                    rsp_valid_d   = 1'b1;
                    state_d       = StResp;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
`endif
            end
            StResp: begin
                if (RSP_READY) begin
                    rsp_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state_q       <= StIdle;
            ptr_q         <= '0;
            tag_q         <= '0;
            eng_valid_q   <= 1'b0;
            eng_data_q    <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
            rsp_error_q   <= 1'b0;
            rsp_channel_q <= '0;
`ifdef FIB_ARB_TIMEOUT_EN
            cnt_q         <= '0;
`endif
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            tag_q         <= tag_d;
            eng_valid_q   <= eng_valid_d;
            eng_data_q    <= eng_data_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            rsp_error_q   <= rsp_error_d;
            rsp_channel_q <= rsp_channel_d;
`ifdef FIB_ARB_TIMEOUT_EN
            cnt_q         <= cnt_d;
`endif
        end
    end

    assign ENG_VALID   = eng_valid_q;
    assign ENG_DATA    = eng_data_q;
    assign RSP_VALID   = rsp_valid_q;
    assign RSP_DATA    = rsp_data_q;
    assign RSP_ERROR   = rsp_error_q;
    assign RSP_CHANNEL = rsp_channel_q;
    assign BUSY        = (state_q != StIdle);

endmodule
